// File: rtl/prime_factorizer_if.sv
// -----------------------------------------------------------------------------
// prime_factorizer_if
//
// This interface bundles the job-side handshake and the prime-generator link of
// the prime_factorizer.
//
// Modports:
//   slave  - the factorizer's view. Inputs: start, n, factor_ack, pg_ready,
//            pg_error, pg_res. Outputs: busy, done, error, factor,
//            factor_valid, pg_rst, pg_go (and nfactors when enabled).
//   master - the job issuer / consumer / generator side. Directions are the
//            reverse of slave.
//
// Optional feature macro: PRIME_FACTORIZER_COUNT_EN adds the nfactors signal.
// -----------------------------------------------------------------------------
interface prime_factorizer_if #(
    parameter int WIDTH_LOG = 4
);
    localparam int WIDTH = 1 << WIDTH_LOG;

    // Job request and status
    logic             start;
    logic [WIDTH-1:0] n;
    logic             busy;
    logic             done;
    logic             error;

    // Factor stream (valid/ack)
    logic [WIDTH-1:0] factor;
    logic             factor_valid;
    logic             factor_ack;

    // Prime generator link
    logic             pg_rst;
    logic             pg_go;
    logic             pg_ready;
    logic             pg_error;
    logic [WIDTH-1:0] pg_res;

`ifdef PRIME_FACTORIZER_COUNT_EN
    logic [WIDTH_LOG:0] nfactors;

    modport slave (
        input  start, n, factor_ack, pg_ready, pg_error, pg_res,
        output busy, done, error, factor, factor_valid, pg_rst, pg_go, nfactors
    );

    modport master (
        output start, n, factor_ack, pg_ready, pg_error, pg_res,
        input  busy, done, error, factor, factor_valid, pg_rst, pg_go, nfactors
    );
`else
    modport slave (
        input  start, n, factor_ack, pg_ready, pg_error, pg_res,
        output busy, done, error, factor, factor_valid, pg_rst, pg_go
    );

    modport master (
        output start, n, factor_ack, pg_ready, pg_error, pg_res,
        input  busy, done, error, factor, factor_valid, pg_rst, pg_go
    );
`endif

endinterface

// File: rtl/prime_factorizer.sv
// -----------------------------------------------------------------------------
// prime_factorizer
//
// This block factors an unsigned integer n into primes by trial division.
// Successive primes 2, 3, 5, ... are requested from an external prime
// generator, which this block restarts at the beginning of every job. Each
// prime p divides the remaining cofactor m in a restoring shift-subtract
// divider that retires one quotient bit per cycle. The prime factors are
// streamed out in ascending order, with multiplicity, over a valid/ack
// handshake.
//
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - prime_factorizer_if.slave:
//          start/n            job request (sampled only while busy=0)
//          busy/done/error    job status (done/error held until next start)
//          factor/factor_valid/factor_ack   factor stream
//          pg_rst/pg_go       restart and next-prime request to the generator
//          pg_ready/pg_error/pg_res         generator response
//          nfactors           factor transfer count (optional)
//
// Optional feature macro: PRIME_FACTORIZER_COUNT_EN adds a saturating count of
// the transferred factors on bus.nfactors.
// -----------------------------------------------------------------------------
module prime_factorizer #(
    parameter int WIDTH_LOG = 4
) (
    input  logic              clk,
    input  logic              rst,
    prime_factorizer_if.slave bus
);

    localparam int WIDTH = 1 << WIDTH_LOG;
    localparam int HI    = WIDTH - 1;

    localparam logic [WIDTH_LOG:0] DIV_STEPS = (WIDTH_LOG + 1)'(WIDTH);
    localparam logic [WIDTH_LOG:0] CNT_LAST  = (WIDTH_LOG + 1)'(1);
    localparam logic [HI:0]        ONE       = WIDTH'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PG_RESET,
        S_PG_REQ,
        S_PG_DLY,
        S_PG_WAIT,
        S_DIV,
        S_CHECK,
        S_EMIT_P,
        S_EMIT_M,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state;
    logic [HI:0]        m;          // remaining cofactor
    logic [HI:0]        p;          // current prime
    logic [HI:0]        q;          // dividend shifts out / quotient shifts in
    logic [HI:0]        r;          // partial remainder
    logic [WIDTH_LOG:0] cnt;        // divider steps left

    logic               busy_q;
    logic               done_q;
    logic               error_q;
    logic [HI:0]        factor_q;
    logic               valid_q;
    logic               go_q;
    logic               pg_rst_q;

    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic               start_ok;
    logic               xfer;

    // One restoring-division step. The shifted remainder needs one extra bit
    // because r < p can still be close to 2^WIDTH. The top bit of the
    // difference is the borrow, and it shows that p did not fit.
    // NOTE: every always_comb output is assigned unconditionally, so no latch is inferred.
    always_comb begin
        rem_shift = {r, q[HI]};
        rem_diff  = rem_shift - {1'b0, p};
        start_ok  = bus.start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
        xfer      = valid_q && bus.factor_ack;
    end

    // NOTE: sequential state uses non-blocking assignments only; the default pulse
    // clears below are overridden by later assignments in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            m        <= '0;
            p        <= '0;
            q        <= '0;
            r        <= '0;
            cnt      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            factor_q <= '0;
            valid_q  <= 1'b0;
            go_q     <= 1'b0;
            pg_rst_q <= 1'b0;
        end else begin
            go_q     <= 1'b0;
            pg_rst_q <= 1'b0;

            unique case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (bus.start) begin
                        m       <= bus.n;
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                        if (bus.n == '0) begin
                            state   <= S_ERROR;
                            error_q <= 1'b1;
                        end else if (bus.n == ONE) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state    <= S_PG_RESET;
                            busy_q   <= 1'b1;
                            pg_rst_q <= 1'b1;
                        end
                    end
                end

                S_PG_RESET: begin
                    state <= S_PG_REQ;
                    go_q  <= 1'b1;
                end

                S_PG_REQ: state <= S_PG_DLY;

                // The generator's ready is registered, so it still shows the
                // previous answer in this cycle and is deliberately not looked at.
                S_PG_DLY: state <= S_PG_WAIT;

                S_PG_WAIT: begin
                    if (bus.pg_error) begin
                        state   <= S_ERROR;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end else if (bus.pg_ready) begin
                        p     <= bus.pg_res;
                        q     <= m;
                        r     <= '0;
                        cnt   <= DIV_STEPS;
                        state <= S_DIV;
                    end
                end

                S_DIV: begin
                    q   <= {q[HI-1:0], ~rem_diff[WIDTH]};
                    r   <= rem_diff[WIDTH] ? rem_shift[HI:0] : rem_diff[HI:0];
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_LAST) state <= S_CHECK;
                end

                // A non-zero remainder with q < p means p*p > m. No prime
                // below sqrt(m) divides it, so m itself is the last factor.
                S_CHECK: begin
                    if (r == '0) begin
                        factor_q <= p;
                        m        <= q;
                        valid_q  <= 1'b1;
                        state    <= S_EMIT_P;
                    end else if (q < p) begin
                        factor_q <= m;
                        valid_q  <= 1'b1;
                        state    <= S_EMIT_M;
                    end else begin
                        go_q  <= 1'b1;
                        state <= S_PG_REQ;
                    end
                end

                // Divide by the same p again after the transfer, to find repeated factors.
                S_EMIT_P: begin
                    if (bus.factor_ack) begin
                        valid_q <= 1'b0;
                        if (m == ONE) begin
                            state  <= S_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            q     <= m;
                            r     <= '0;
                            cnt   <= DIV_STEPS;
                            state <= S_DIV;
                        end
                    end
                end

                S_EMIT_M: begin
                    if (bus.factor_ack) begin
                        valid_q <= 1'b0;
                        state   <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef PRIME_FACTORIZER_COUNT_EN
    logic [WIDTH_LOG:0] nfactors_q;

    // Counts factor transfers of the current job and saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            nfactors_q <= '0;
        end else if (start_ok) begin
            nfactors_q <= '0;
        end else if (xfer && (nfactors_q != '1)) begin
            nfactors_q <= nfactors_q + 1'b1;
        end
    end

    assign bus.nfactors = nfactors_q;
`else
    // Without the counter, these terms only feed the optional logic.
    logic unused_ok;
    assign unused_ok = start_ok ^ xfer;
`endif

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.error        = error_q;
    assign bus.factor       = factor_q;
    assign bus.factor_valid = valid_q;
    assign bus.pg_go        = go_q;
    // The generator is held in reset together with this block.
    assign bus.pg_rst       = rst | pg_rst_q;

endmodule

// File: doc/prime_factorizer.md
Name: prime_factorizer

Overview:
- Initiator-side consumer of the prime generator's go/ready/error/res protocol.
- Takes an unsigned integer n and drives an external prime generator to obtain successive primes 2, 3, 5, 7, ...
- Trial-divides n with an internal shift-subtract divider.
- Streams the prime factors of n, in ascending order and with multiplicity, over a valid/ack output handshake.
- Sits beside one prime generator instance and owns that instance's go and its per-job restart.

Parameters:
- WIDTH_LOG, 4, log2 of the datapath width. WIDTH = 1 << WIDTH_LOG; HI = WIDTH-1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  job request; sampled only when busy=0.
- n  input  WIDTH  number to factor; latched when start is accepted.
- busy  output  1  job in progress.
- done  output  1  last job completed normally; held until the next accepted start or rst.
- error  output  1  last job failed; held until the next accepted start or rst.
- factor  output  WIDTH  current factor; stable while factor_valid=1.
- factor_valid  output  1  factor is presented.
- factor_ack  input  1  consumer accepts factor; a transfer occurs when factor_valid && factor_ack.
- pg_rst  output  1  restart request to the prime generator.
- pg_go  output  1  single-cycle next-prime request.
- pg_ready  input  1  generator ready.
- pg_error  input  1  generator overflow.
- pg_res  input  WIDTH  generator result.

Behaviour:
- Reset values: busy=0, done=0, error=0, factor_valid=0, factor=0, pg_go=0, pg_rst=1 (pg_rst = rst OR internal pulse). State goes to IDLE.
- All outputs are registered, except that pg_rst includes the rst term.
- Internal registers: m (remaining cofactor), p (current prime), q (quotient), r (remainder), each WIDTH bits. Divider bit counter is WIDTH_LOG+1 bits.
- IDLE/DONE/ERROR with start=1: latch m=n; clear done and error.
  - n==0: go to ERROR next cycle.
  - n==1: go to DONE next cycle; no factors emitted.
  - Otherwise: go to PG_RESET; busy=1.
- PG_RESET: pg_rst=1 for exactly one cycle. The generator then holds res=1 and ready=1. Go to PG_REQ.
- PG_REQ: pg_go=1 for one cycle. Go to PG_DLY.
- PG_DLY: one cycle in which pg_ready is ignored, because the generator's ready is registered and still shows the stale 1. Go to PG_WAIT.
- PG_WAIT:
  - pg_error=1: go to ERROR (busy=0, error=1).
  - pg_ready=1: p=pg_res; go to DIV.
  - Otherwise: stay.
- DIV: restoring divide of m by p, one quotient bit per cycle, exactly WIDTH cycles; produces q and r. Go to CHECK.
- CHECK:
  - r==0: factor=p; m=q; go to EMIT_P.
  - r!=0 and q<p (equivalent to p*p>m; no multiplier is used): factor=m; go to EMIT_M.
  - Otherwise: go to PG_REQ.
- EMIT_P: factor_valid=1. On transfer: factor_valid=0 next cycle. If m==1 go to DONE, else go to DIV with the same p.
- EMIT_M: factor_valid=1. On transfer: go to DONE.
- DONE: done=1, busy=0. ERROR: error=1, busy=0.
- Latency: the first factor is valid no earlier than 5+WIDTH cycles after start acceptance.
- factor_valid drops for at least one cycle between consecutive factors.
- factor and factor_valid must not change while factor_valid=1 and factor_ack=0.
- factor_ack while factor_valid=0 is ignored.
- start while busy=1 is ignored; n is not re-latched.
- rst mid-job, including mid-EMIT: immediate return to IDLE, factor_valid=0, and the pending factor is dropped.
- Division by zero cannot occur (p>=2). The divider uses no state beyond m, p, q, r and the counter.

Optional Feature:
- Macro PRIME_FACTORIZER_COUNT_EN.
- Defined:
  - Adds output nfactors, WIDTH_LOG+1 bits, reset 0.
  - Cleared on start acceptance; incremented on each factor transfer.
  - Saturates at all-ones.
  - Holds its value in DONE and ERROR.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- n=12, factor_ack tied 1 -> factors 2, 2, 3 in order, then done=1, error=0, busy=0.
- n=13 -> generator requested for 2, 3, 5. The q<p check hits at p=5 (q=2). Single factor 13, then done.
- n=65535 (WIDTH_LOG=4) -> factors 3, 5, 17, 257. 257 is emitted via the q<p path at p=17.
- n=1 -> done=1 two cycles after start, no factor_valid pulse. n=0 -> error=1, pg_go never asserted.
- n=8 with factor_ack low for 10 cycles on each factor -> factor=2 held stable while stalled. Three transfers, then done. With PRIME_FACTORIZER_COUNT_EN, nfactors=3.
- Generator model asserts pg_error on the 3rd request -> error=1, busy=0, no further pg_go. Then rst asserted during a DIV of a new job -> IDLE, factor_valid=0; a following start with n=6 yields 2, 3.
